// File: rtl/add_pipe.sv
// add_pipe: pipelined integer adder/comparator for the execute path.
// The WIDTH-bit carry chain is cut into STAGES equal slices. Stage k adds
// slice k and registers its carry for stage k+1, so each stage carries only
// SW = WIDTH/STAGES bits of ripple. Both ends use valid/ready handshakes
// with full backpressure, and flush discards everything in flight.
//
// The last-stage registers act as the output registers. out, ovf and zero
// are decoded from them combinationally, so they cannot change while a
// result is stalled.

module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    // Per-stage registers. The full operand words travel down the pipe:
    // later stages need the high slices they have not added yet, and the
    // last stage needs both sign bits to detect overflow.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [1:0]        op_q  [STAGES];
    logic [STAGES-1:0] cy_q;

    // Values presented to each stage and the values that stage will load.
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [1:0]        op_d  [STAGES];
    logic [STAGES-1:0] cin;
    logic [STAGES-1:0] cy_d;
    logic [SW:0]       slice_sum;

    // Handshake chain.
    // ready[k]: stage k can take a new entry this cycle.
    // drain[k]: stage k's current entry leaves this cycle.
    // load[k]:  stage k captures a new entry this cycle.
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] drain;
    logic [STAGES-1:0] load;

    // Output decode signals.
    logic a_msb;
    logic b_msb;
    logic s_msb;
    logic ovf_raw;

    // Backpressure: readiness ripples from the output back to the input,
    // so a full pipe can accept a new entry in the same cycle its output
    // is consumed.
    always_comb begin
        ready   = '0;
        drain   = '0;
        load    = '0;
        valid_d = '0;
        drain[STAGES-1] = valid_q[STAGES-1] && out_ready;
        ready[STAGES-1] = !valid_q[STAGES-1] || drain[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            drain[k] = valid_q[k] && ready[k+1];
            ready[k] = !valid_q[k] || drain[k];
        end
        load[0] = in_valid && ready[0];
        for (int k = 1; k < STAGES; k++) begin
            load[k] = valid_q[k-1] && ready[k];
        end
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = load[k] || (valid_q[k] && !drain[k]);
        end
    end

    // Datapath: route each stage's input and add its own carry-chain slice.
    always_comb begin
        slice_sum = '0;
        a_d[0]    = in0;
        b_d[0]    = (op == OP_ADD) ? in1 : ~in1;
        sum_d[0]  = '0;
        op_d[0]   = op;
        cin       = '0;
        cin[0]    = (op != OP_ADD);
        cy_d      = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            sum_d[k] = sum_q[k-1];
            op_d[k]  = op_q[k-1];
            cin[k]   = cy_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_sum = {1'b0, a_d[k][k*SW +: SW]}
                      + {1'b0, b_d[k][k*SW +: SW]}
                      + {{SW{1'b0}}, cin[k]};
            sum_d[k][k*SW +: SW] = slice_sum[SW-1:0];
            cy_d[k]              = slice_sum[SW];
        end
    end

    // Stage registers. Data registers load only when the stage takes a
    // new entry, which keeps a stalled result stable. Flush clears only
    // the valid bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            cy_q    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                op_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    sum_q[k] <= sum_d[k];
                    op_q[k]  <= op_d[k];
                    cy_q[k]  <= cy_d[k];
                end
            end
            if (flush) begin
                valid_q <= '0;
            end else begin
                valid_q <= valid_d;
            end
        end
    end

    // Result decode from the last stage. b_q already holds the inverted
    // operand for SUB and compares, so one overflow rule covers both ADD
    // and SUB.
    always_comb begin
        a_msb   = a_q[STAGES-1][WIDTH-1];
        b_msb   = b_q[STAGES-1][WIDTH-1];
        s_msb   = sum_q[STAGES-1][WIDTH-1];
        ovf_raw = (a_msb == b_msb) && (s_msb != a_msb);
        out     = sum_q[STAGES-1];
        ovf     = 1'b0;
        case (op_q[STAGES-1])
            OP_ADD, OP_SUB: begin
                ovf = ovf_raw;
            end
            OP_SLT: begin
                out    = '0;
                out[0] = s_msb ^ ovf_raw;
            end
            OP_SLTU: begin
                out    = '0;
                out[0] = ~cy_q[STAGES-1];
            end
            default: begin
                out = sum_q[STAGES-1];
            end
        endcase
    end

    assign carry     = cy_q[STAGES-1];
    assign zero      = (out == '0);
    assign out_valid = valid_q[STAGES-1];
    assign in_ready  = ready[0];

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: bench for add_pipe.
// Directed cases run on a (32,2) instance. Random traffic with random
// flush and backpressure runs on (32,1), (32,4) and (16,2) instances.
// Results are checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_add_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model written as plain arithmetic on the operand values.
    // Returns {zero, ovf, carry, result}.
    function automatic logic [34:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic [1:0] opc);
        longint unsigned m, ua, ub, r;
        longint sa, sb, lim;
        logic c, v;
        m   = (64'd1 << w) - 64'd1;
        ua  = {32'd0, a} & m;
        ub  = {32'd0, b} & m;
        lim = longint'(64'd1 << (w - 1));
        sa  = (longint'(ua) >= lim) ? longint'(ua) - 2 * lim : longint'(ua);
        sb  = (longint'(ub) >= lim) ? longint'(ub) - 2 * lim : longint'(ub);
        c   = (ua >= ub);
        v   = 1'b0;
        case (opc)
            2'd0: begin
                r = (ua + ub) & m;
                c = ((ua + ub) > m);
                v = (sa + sb >= lim) || (sa + sb < -lim);
            end
            2'd1: begin
                r = (ua - ub) & m;
                v = (sa - sb >= lim) || (sa - sb < -lim);
            end
            2'd2:    r = (sa < sb) ? 64'd1 : 64'd0;
            default: r = (ua < ub) ? 64'd1 : 64'd0;
        endcase
        return {(r == 64'd0), v, c, r[31:0]};
    endfunction

    // ---------------- directed instance (32,2) ----------------
    logic        d_rstn, d_fl, d_iv, d_ir, d_ov, d_or, d_cy, d_vf, d_zr;
    logic [31:0] d_a, d_b, d_o;
    logic [1:0]  d_op;

    add_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .resetn(d_rstn), .flush(d_fl),
        .in_valid(d_iv), .in_ready(d_ir), .in0(d_a), .in1(d_b), .op(d_op),
        .out_valid(d_ov), .out_ready(d_or), .out(d_o),
        .carry(d_cy), .ovf(d_vf), .zero(d_zr)
    );

    // Sends one operation into an otherwise empty pipe, then checks the
    // latency and the result, and that the result leaves on the next edge.
    task automatic run_op(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [1:0] op_v, input logic [34:0] exp);
        int lat;
        @(negedge clk);
        d_iv = 1'b1; d_a = a_v; d_b = b_v; d_op = op_v; d_or = 1'b1;
        #1 check({tag, "_rdy"}, d_ir, 1);
        @(negedge clk);
        d_iv = 1'b0;
        lat  = 1;
        #1;
        while (!d_ov && lat < 10) begin
            @(negedge clk);
            lat++;
            #1;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_res"}, {d_zr, d_vf, d_cy, d_o}, exp);
        @(negedge clk);
        #1 check({tag, "_gone"}, d_ov, 0);
    endtask

    // ---------------- random instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int W = (g == 2) ? 16 : 32;
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 4 : 2);

        logic         rstn, fl, iv, ir, ov, orr, cy, vf, zr;
        logic [W-1:0] a, b, o;
        logic [1:0]   opc;
        logic         done = 1'b0;

        add_pipe #(.WIDTH(W), .STAGES(S)) dut_r (
            .clk(clk), .resetn(rstn), .flush(fl),
            .in_valid(iv), .in_ready(ir), .in0(a), .in1(b), .op(opc),
            .out_valid(ov), .out_ready(orr), .out(o),
            .carry(cy), .ovf(vf), .zero(zr)
        );

        function automatic logic [W-1:0] pick_operand();
            case ($urandom_range(0, 11))
                0:       return '0;
                1:       return '1;
                2:       return {1'b1, {(W-1){1'b0}}};
                3:       return {1'b0, {(W-1){1'b1}}};
                default: return W'($urandom);
            endcase
        endfunction

        initial begin
            int          sent, cyc;
            logic [34:0] q[$];
            logic [34:0] held, e;
            logic        hold;
            sent = 0; cyc = 0; hold = 1'b0; held = '0;
            rstn = 1'b0; fl = 1'b0; iv = 1'b0; orr = 1'b0;
            a = '0; b = '0; opc = 2'd0;
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                orr = ($urandom_range(0, 3) != 0);
                fl  = ($urandom_range(0, 59) == 0);
                if (sent < 1000) begin
                    iv  = ($urandom_range(0, 4) != 0);
                    a   = pick_operand();
                    b   = pick_operand();
                    opc = 2'($urandom_range(0, 3));
                end else begin
                    iv = 1'b0;
                end
                #1;
                if (hold) begin
                    check($sformatf("r%0d_hold_valid", g), ov, 1);
                    check($sformatf("r%0d_hold_data", g), {zr, vf, cy, 32'(o)}, held);
                end
                hold = ov && !orr && !fl;
                held = {zr, vf, cy, 32'(o)};
                if (ov && orr) begin
                    if (q.size() == 0) begin
                        check($sformatf("r%0d_spurious", g), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("r%0d_res", g), {zr, vf, cy, 32'(o)}, e);
                    end
                end
                if (fl) begin
                    q.delete();
                end else if (iv && ir) begin
                    q.push_back(ref_op(W, 32'(a), 32'(b), opc));
                end
                if (iv && ir) sent++;
            end
            check($sformatf("r%0d_finished", g), (cyc < 20000), 1);
            done = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          sent, got, first_c, last_c;
        logic        stall;
        logic [31:0] held;

        d_rstn = 1'b0; d_fl = 1'b0; d_iv = 1'b0; d_or = 1'b0;
        d_a = '0; d_b = '0; d_op = 2'd0;
        #3;
        check("rst_valid", d_ov, 0);
        check("rst_out", d_o, 0);
        check("rst_carry", d_cy, 0);
        check("rst_ovf", d_vf, 0);
        check("rst_zero", d_zr, 1);
        @(negedge clk);
        @(negedge clk);
        d_rstn = 1'b1;
        #1 check("rst_rel_rdy", d_ir, 1);

        run_op("add_slice",  32'h0000FFFF, 32'h00000001, 2'd0, {1'b0, 1'b0, 1'b0, 32'h00010000});
        run_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 2'd0, {1'b0, 1'b1, 1'b0, 32'h80000000});
        run_op("add_carry",  32'hFFFFFFFF, 32'h00000001, 2'd0, {1'b1, 1'b0, 1'b1, 32'h00000000});
        run_op("sub_zero",   32'd5,        32'd5,        2'd1, {1'b1, 1'b0, 1'b1, 32'h00000000});
        run_op("sub_neg",    32'd3,        32'd5,        2'd1, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFE});
        run_op("slt_neg",    32'hFFFFFFFF, 32'h00000001, 2'd2, {1'b0, 1'b0, 1'b1, 32'h00000001});
        run_op("sltu_big",   32'hFFFFFFFF, 32'h00000001, 2'd3, {1'b1, 1'b0, 1'b1, 32'h00000000});
        run_op("slt_ovfcmp", 32'h80000000, 32'h7FFFFFFF, 2'd2, {1'b0, 1'b0, 1'b1, 32'h00000001});

        // Backpressure: six ADDs i+i, output stalled for the first 5 cycles.
        sent = 0; got = 0; first_c = -1; last_c = -1; stall = 1'b0; held = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            d_or = (c >= 5);
            d_iv = (sent < 6);
            d_a  = 32'(sent + 1);
            d_b  = 32'(sent + 1);
            d_op = 2'd0;
            #1;
            if (stall) begin
                check("bp_hold_valid", d_ov, 1);
                check("bp_hold_out", d_o, held);
            end
            stall = d_ov && !d_or;
            held  = d_o;
            if (c == 2) begin
                check("bp_rdy_low", d_ir, 0);
                check("bp_accepts", sent, 2);
            end
            if (c == 4) check("bp_rdy_still_low", d_ir, 0);
            if (d_ov && d_or) begin
                check("bp_order", d_o, 32'(2 * (got + 1)));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (d_iv && d_ir) sent++;
        end
        check("bp_count", got, 6);
        check("bp_first", first_c, 5);
        check("bp_rate", last_c - first_c, 5);
        @(negedge clk);
        d_iv = 1'b0;
        #1 check("bp_empty", d_ov, 0);

        // Flush: two ops in flight, a third offered in the flush cycle.
        @(negedge clk);
        d_or = 1'b0; d_iv = 1'b1; d_a = 32'd10; d_b = 32'd20; d_op = 2'd0;
        @(negedge clk);
        d_a = 32'd30; d_b = 32'd40;
        @(negedge clk);
        d_fl = 1'b1; d_or = 1'b1; d_a = 32'd50; d_b = 32'd60;
        #1 check("fl_in_hs", d_ir, 1);
        @(negedge clk);
        d_fl = 1'b0; d_a = 32'd100; d_b = 32'd23; d_op = 2'd1;
        #1;
        check("fl_cleared", d_ov, 0);
        check("fl_rdy", d_ir, 1);
        @(negedge clk);
        d_iv = 1'b0;
        #1 check("fl_none1", d_ov, 0);
        @(negedge clk);
        #1;
        check("fl_post_valid", d_ov, 1);
        check("fl_post_res", {d_zr, d_vf, d_cy, d_o}, {1'b0, 1'b0, 1'b1, 32'd77});
        @(negedge clk);
        #1 check("fl_none2", d_ov, 0);

        // Asynchronous reset with the pipe full.
        @(negedge clk);
        d_or = 1'b0; d_iv = 1'b1; d_a = 32'd7; d_b = 32'd8; d_op = 2'd0;
        @(negedge clk);
        d_a = 32'd9;
        @(negedge clk);
        d_iv = 1'b0;
        #1;
        check("ar_full_valid", d_ov, 1);
        check("ar_full_rdy", d_ir, 0);
        #1 d_rstn = 1'b0;
        #1;
        check("ar_valid", d_ov, 0);
        check("ar_out", d_o, 0);
        check("ar_carry", d_cy, 0);
        check("ar_zero", d_zr, 1);
        @(negedge clk);
        d_rstn = 1'b1;
        #1 check("ar_rel_rdy", d_ir, 1);

        wait (g_rand[0].done && g_rand[1].done && g_rand[2].done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
